sseg_scan_driver: RTL and testbench

SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

---
 rtl/sseg_scan_driver.sv | 96 +++++++++
 tb/tb_sseg_scan_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed 7-segment driver: signed 12-bit value shown as sign + 3 hex digits.
// Ports: clk, rst (sync high), load/value capture; segs[6:0]=g..a and an[3:0] active-low, registered.
// Optional: define SSEG_LZ_BLANK_EN to blank leading-zero digits d2/d1.
module sseg_scan_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] value,
  output logic [6:0]  segs,
  output logic [3:0]  an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CMAX = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_NEG   = 7'b011_1111;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    nidx;
  logic [11:0]   held;
  logic [11:0]   mag;
  logic          neg;
  logic          tick;
  logic [6:0]    nxt_segs;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b100_0000;
      4'h1: s = 7'b111_1001;
      4'h2: s = 7'b010_0100;
      4'h3: s = 7'b011_0000;
      4'h4: s = 7'b001_1001;
      4'h5: s = 7'b001_0010;
      4'h6: s = 7'b000_0010;
      4'h7: s = 7'b111_1000;
      4'h8: s = 7'b000_0000;
      4'h9: s = 7'b001_1000;
      4'hA: s = 7'b000_1000;
      4'hB: s = 7'b000_0011;
      4'hC: s = 7'b100_0110;
      4'hD: s = 7'b010_0001;
      4'hE: s = 7'b000_0110;
      default: s = 7'b000_1110;
    endcase
    return s;
  endfunction

  assign tick = (cnt == CMAX);
  assign nidx = idx + 2'd1;
  assign neg  = held[11];
  // -2048 negates to itself, which reads correctly as unsigned 0x800
  assign mag  = neg ? (~held + 12'd1) : held;

  // Pattern for the digit that becomes active on the next tick
  always_comb begin
    nxt_segs = SEG_BLANK;
    case (nidx)
      2'd0:    nxt_segs = hex7(mag[3:0]);
      2'd1:    nxt_segs = hex7(mag[7:4]);
      2'd2:    nxt_segs = hex7(mag[11:8]);
      default: nxt_segs = neg ? SEG_NEG : SEG_BLANK;
    endcase
`ifdef SSEG_LZ_BLANK_EN
    if (nidx == 2'd2 && mag[11:8] == 4'd0)
      nxt_segs = SEG_BLANK;
    if (nidx == 2'd1 && mag[11:4] == 8'd0)
      nxt_segs = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= 2'd3;
      held <= '0;
      segs <= SEG_BLANK;
      an   <= 4'b1111;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (load)
        held <= value;
      // held is read before this edge's load lands
      if (tick) begin
        idx  <= nidx;
        segs <= nxt_segs;
        an   <= ~(4'b0001 << nidx);
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with REFRESH_DIV=4.
// Tracks tick phase and digit index locally; checks every edge.
module tb_sseg_scan_driver;

  logic        clk;
  logic        rst;
  logic        load;
  logic [11:0] value;
  logic [6:0]  segs;
  logic [3:0]  an;

  int errors;
  int checks;
  int ph;
  logic [1:0] eidx;
  bit tick;
  logic [3:0] cur_an;
  logic [6:0] cur_segs;

`ifdef SSEG_LZ_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] t_zero [4] = '{7'h40, LZ, LZ, 7'h7F};
  logic [6:0] t_1a3  [4] = '{7'h30, 7'h08, 7'h79, 7'h7F};
  logic [6:0] t_ffb  [4] = '{7'h12, LZ, LZ, 7'h3F};
  logic [6:0] t_800  [4] = '{7'h40, 7'h40, 7'h00, 7'h3F};
  logic [6:0] t_00f  [4] = '{7'h0E, LZ, LZ, 7'h7F};

  sseg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (value),
    .segs  (segs),
    .an    (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) begin
      ph = 0;
      eidx = 2'd3;
      tick = 1'b0;
    end else if (ph == 3) begin
      ph = 0;
      eidx = eidx + 2'd1;
      tick = 1'b1;
    end else begin
      ph++;
      tick = 1'b0;
    end
  endtask

  task automatic check_hold(input string name);
    checks++;
    if (an !== cur_an || segs !== cur_segs) begin
      errors++;
      $display("FAIL %s: an=%b segs=%b, want an=%b segs=%b",
               name, an, segs, cur_an, cur_segs);
    end
  endtask

  task automatic hold_step(input string name);
    step();
    check_hold(name);
  endtask

  task automatic tick_check(input string name, input logic [6:0] tab [4]);
    bit got;
    got = 1'b0;
    repeat (4) begin
      if (!got) begin
        step();
        if (tick) got = 1'b1;
        else check_hold({name, "_hold"});
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no tick within 4 edges", name);
    end else if (an !== an_tab[eidx] || segs !== tab[eidx]) begin
      errors++;
      $display("FAIL %s: an=%b segs=%b, want an=%b segs=%b",
               name, an, segs, an_tab[eidx], tab[eidx]);
    end
    cur_an = an_tab[eidx];
    cur_segs = tab[eidx];
  endtask

  task automatic do_load(input logic [11:0] v);
    load = 1'b1;
    value = v;
    hold_step("load_between_ticks");
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cur_an = 4'b1111;
    cur_segs = 7'h7F;
    repeat (3) hold_step("reset_held");
    rst = 1'b0;
    tick_check("reset_first_tick_d0", t_zero);
  endtask

  task automatic test_hex_scan();
    do_load(12'h1A3);
    repeat (4) tick_check("scan_1a3", t_1a3);
  endtask

  task automatic test_negative();
    do_load(12'hFFB);
    repeat (4) tick_check("scan_neg5", t_ffb);
  endtask

  task automatic test_min_value();
    do_load(12'h800);
    repeat (4) tick_check("scan_min", t_800);
  endtask

  task automatic test_back_to_back();
    do_load(12'h1A3);
    tick_check("b2b_old", t_1a3);
    while (ph != 3) hold_step("b2b_wait");
    load = 1'b1;
    value = 12'h00F;
    step();
    load = 1'b0;
    checks++;
    if (!tick || an !== an_tab[eidx] || segs !== t_1a3[eidx]) begin
      errors++;
      $display("FAIL b2b_coincident: tick=%0d an=%b segs=%b, want an=%b segs=%b",
               tick, an, segs, an_tab[eidx], t_1a3[eidx]);
    end
    cur_an = an_tab[eidx];
    cur_segs = t_1a3[eidx];
    tick_check("b2b_new", t_00f);
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (eidx != 2'd2 && n < 4) begin
      tick_check("mid_pre", t_00f);
      n++;
    end
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL mid_pre_an: an=%b, want 1011", an);
    end
    hold_step("mid_between");
    rst = 1'b1;
    load = 1'b1;
    value = 12'h1A3;
    step();
    rst = 1'b0;
    load = 1'b0;
    cur_an = 4'b1111;
    cur_segs = 7'h7F;
    check_hold("mid_reset_edge");
    tick_check("mid_restart_d0", t_zero);
    tick_check("mid_restart_d1", t_zero);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ph = 0;
    eidx = 2'd3;
    tick = 1'b0;
    rst = 1'b1;
    load = 1'b0;
    value = '0;
    cur_an = 4'b1111;
    cur_segs = 7'h7F;
    test_reset();
    test_hex_scan();
    test_negative();
    test_min_value();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
